serial_addsub_unit: RTL and testbench

Parametrised, slice-serial unsigned add/subtract/compare unit for N-bit balance and amount arithmetic in the ATM datapath. Operands are captured on a start pulse and processed W bits per clock through a single registered carry, so area stays at one W-bit adder slice regardless of N. Results and flags (carry, borrow, equal) are held stable after a one-cycle done pulse until the next operation completes. It replaces the flat combinational ripple adder wherever a transaction controller needs subtraction and an insufficient-funds check.

---
 rtl/serial_addsub_unit.sv | 159 +++++++++++++++
 tb/tb_serial_addsub_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_unit.sv
// Slice-serial unsigned add / subtract / compare unit: one W-bit adder slice,
// a registered carry, and registered result/flags held between done pulses.
module serial_addsub_unit #(
    parameter int N = 10,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         borrow,
    output logic         equal
);

    localparam int SLICES = N / W;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   sum_reg;
    logic [N-1:0]   sum_merge;
    logic [1:0]     op_reg;
    logic           carry_reg;
    logic           zero_reg;
    logic [CW-1:0]  cnt_reg;

    logic [W-1:0]   a_sl [SLICES];
    logic [W-1:0]   b_sl [SLICES];
    logic [W-1:0]   a_slice;
    logic [W-1:0]   b_slice;
    logic [W-1:0]   slice_sum;
    logic           slice_carry;
    logic           accept;
    logic           last;
    logic           final_zero;

    // Operand slices as an array so the active slice is a plain mux on the counter.
    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*W +: W];
            assign b_sl[gi] = b_reg[gi*W +: W];
            assign sum_merge[gi*W +: W] = (cnt_reg == CW'(gi)) ? slice_sum
                                                                : sum_reg[gi*W +: W];
        end
    endgenerate

    assign accept = (state_reg != RUN) && start && (op != OP_RSV);
    assign last   = (cnt_reg == CW'(SLICES - 1));

    always_comb begin
        a_slice = a_sl[cnt_reg];
        b_slice = b_sl[cnt_reg];
        {slice_carry, slice_sum} = {1'b0, a_slice} + {1'b0, b_slice}
                                 + {{W{1'b0}}, carry_reg};
        final_zero = ~(zero_reg | (|slice_sum));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                state_next = accept ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            op_reg    <= OP_ADD;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            cnt_reg   <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            borrow    <= 1'b0;
            equal     <= 1'b0;
        end else if (accept) begin
            // Subtract and compare run as a + ~b + 1.
            a_reg     <= a;
            b_reg     <= (op == OP_ADD) ? b : ~b;
            carry_reg <= (op != OP_ADD);
            op_reg    <= op;
            zero_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_merge;
            carry_reg <= slice_carry;
            zero_reg  <= zero_reg | (|slice_sum);
            cnt_reg   <= cnt_reg + CW'(1);
            if (last) begin
                case (op_reg)
                    OP_ADD: begin
                        result    <= sum_merge;
                        carry_out <= slice_carry;
                        borrow    <= 1'b0;
                        equal     <= 1'b0;
                    end
                    OP_SUB: begin
                        result    <= sum_merge;
                        carry_out <= 1'b0;
                        borrow    <= ~slice_carry;
                        equal     <= final_zero & slice_carry;
                    end
                    OP_CMP: begin
                        carry_out <= 1'b0;
                        borrow    <= ~slice_carry;
                        equal     <= final_zero & slice_carry;
                    end
                    default: begin
                        carry_out <= carry_out;
                    end
                endcase
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit: directed operations push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_serial_addsub_unit;

    localparam int N = 10;
    localparam int W = 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry_out;
    logic         borrow;
    logic         equal;

    typedef struct {
        logic [N-1:0] r;
        logic         co;
        logic         bo;
        logic         eq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    serial_addsub_unit #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .borrow    (borrow),
        .equal     (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [N-1:0] r, input logic co, input logic bo, input logic eq);
        exp_t e;
        e.r = r; e.co = co; e.bo = bo; e.eq = eq;
        exp_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 result=%0d", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.r));
                check("carry_out", 32'(carry_out), 32'(e.co));
                check("borrow", 32'(borrow), 32'(e.bo));
                check("equal", 32'(equal), 32'(e.eq));
                $display("done: result=%0d carry_out=%0b borrow=%0b equal=%0b", result, carry_out, borrow, equal);
            end
        end
    end

    // One operation; measures start-to-done edges. poke pulses a second start
    // with different operands during RUN, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic [N-1:0] r, input logic co, input logic bo, input logic eq,
                          input bit poke);
        int edges;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        push(r, co, bo, eq);
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        check("busy_after_e0", 32'(busy), 32'd1);
        while (!done && edges < 20) begin
            if (poke && edges == 2) begin
                start = 1'b1; a = 10'd1; b = 10'd1;
            end else if (poke && edges == 3) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        check("latency_edges", 32'(edges), 32'd6);
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({carry_out, borrow, equal}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(2'b00, 10'd300,  10'd200, 10'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2'b00, 10'd1000, 10'd100, 10'd76,  1'b1, 1'b0, 1'b0, 1'b0);
        run_op(2'b01, 10'd150,  10'd400, 10'd774, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2'b01, 10'd400,  10'd400, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0);
        run_op(2'b00, 10'd300,  10'd200, 10'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 10'd5,    10'd9,   10'd500, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2'b01, 10'd9,    10'd5,   10'd4,   1'b0, 1'b0, 1'b0, 1'b0);

        // Start pulse during RUN is ignored; no second done may follow.
        run_op(2'b00, 10'd10, 10'd20, 10'd30, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        // Start held across DONE: operands changed during RUN take effect only
        // for the second, back-to-back operation.
        @(negedge clk);
        op = 2'b00; a = 10'd7; b = 10'd8; start = 1'b1;
        push(10'd15, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 10'd100; b = 10'd23;
        push(10'd123, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (!done && guard < 20) begin @(posedge clk); #1; guard++; end
        check("b2b_first_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("b2b_busy_no_idle", 32'(busy), 32'd1);
        check("b2b_done_dropped", 32'(done), 32'd0);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin @(posedge clk); #1; guard++; end
        check("b2b_second_done", 32'(done), 32'd1);
        @(negedge clk);

        // Reserved op: nothing happens.
        @(negedge clk);
        op = 2'b11; a = 10'd1; b = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rsv_busy_done", 32'({busy, done}), 32'd0);
            @(posedge clk); #1;
        end

        // Reset at the third RUN edge aborts and clears everything.
        @(negedge clk);
        op = 2'b00; a = 10'd50; b = 10'd60; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({carry_out, borrow, equal}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(2'b00, 10'd123, 10'd456, 10'd579, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
